// File: rtl/rsa_ui_ctrl.sv
// RSA front-panel controller: decimal key entry, key storage and
// engine sequencing (start, abort, timeout) for keygen/encrypt/decrypt.
module rsa_ui_ctrl #(
  parameter int KEY_W    = 32,
  parameter int NUM_KEYS = 3,
  parameter int DIGITS   = 10,
  parameter int TIMEOUT  = 2**24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [$clog2(NUM_KEYS)-1:0]   key_sel,
  input  logic                          btn_add,
  input  logic                          btn_left,
  input  logic                          btn_del,
  input  logic                          btn_start,
  input  logic                          eng_busy,
  input  logic                          eng_done,
  input  logic                          kg_valid,
  input  logic [$clog2(NUM_KEYS)-1:0]   kg_idx,
  input  logic [KEY_W-1:0]              kg_data,
  output logic                          eng_start,
  output logic                          eng_abort,
  output logic [NUM_KEYS*KEY_W-1:0]     keys_flat,
  output logic [KEY_W-1:0]              show_key,
  output logic [3:0]                    show_mode,
  output logic                          typing,
  output logic [$clog2(DIGITS)-1:0]     cursor,
  output logic                          working,
  output logic                          err
);

  localparam int KSW = $clog2(NUM_KEYS);
  localparam int CW  = $clog2(DIGITS);
  localparam int VW  = 4 * DIGITS;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_EDIT = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0]   keys_q, keys_d;
  logic [DIGITS-1:0][3:0]           dig_q, dig_d;
  logic [CW-1:0]                    cur_q, cur_d;
  logic [TW-1:0]                    tmo_q, tmo_d;
  logic [1:0]                       mode_q;
  logic [KSW-1:0]                   sel_q;

  logic                             start_q, start_d;
  logic                             abort_q, abort_d;
  logic                             err_q, err_d;
  logic                             typ_q, typ_d;
  logic                             wrk_q, wrk_d;
  logic [KEY_W-1:0]                 shk_q, shk_d;
  logic [3:0]                       shm_q, shm_d;

  logic                             edit;
  logic                             mode_chg;
  logic                             sel_chg;
  logic                             sel_ok;
  logic                             kg_ok;
  logic [VW-1:0]                    val_q;
  logic                             busy_unused;

  assign busy_unused = eng_busy;

  function automatic logic [VW-1:0] dec_val(
    input logic [DIGITS-1:0][3:0] d
  );
    logic [VW-1:0] v;
    v = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * VW'(10) + VW'(d[i]);
    end
    return v;
  endfunction

  assign val_q    = dec_val(dig_q);
  assign mode_chg = (mode != mode_q);
  assign sel_chg  = (key_sel != sel_q);
  assign sel_ok   = (int'(key_sel) < NUM_KEYS);
  assign kg_ok    = (int'(kg_idx) < NUM_KEYS);

  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    dig_d   = dig_q;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    edit    = 1'b0;

    if (mode == 2'b00) begin
      abort_d = (state_q == S_RUN);
      state_d = S_OFF;
      keys_d  = '0;
      dig_d   = '0;
      cur_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_IDLE;
        S_IDLE: begin
          if (btn_start) begin
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = S_RUN;
          end else if (mode[1] && (btn_add || btn_left || btn_del)) begin
            dig_d   = '0;
            cur_d   = '0;
            edit    = 1'b1;
            state_d = S_EDIT;
          end
        end
        S_EDIT: begin
          if (mode_chg || sel_chg) begin
            state_d = S_IDLE;
          end else if (btn_start) begin
            if (|val_q[VW-1:KEY_W]) begin
              err_d = 1'b1;
            end else begin
              if (sel_ok) keys_d[key_sel] = val_q[KEY_W-1:0];
              state_d = S_IDLE;
            end
          end else begin
            edit = 1'b1;
          end
        end
        S_RUN: begin
          if (mode_chg) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (kg_valid && mode == 2'b01) begin
              if (kg_ok) keys_d[kg_idx] = kg_data;
              else       err_d = 1'b1;
            end
            // a result written alongside eng_done is still kept
            if (eng_done) begin
              state_d = S_IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              err_d   = 1'b1;
              abort_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // one edit action per cycle: del > left > add
    if (edit) begin
      if (btn_del) begin
        dig_d[cur_d] = 4'd0;
        cur_d = (cur_d == '0) ? '0 : cur_d - CW'(1);
      end else if (btn_left) begin
        cur_d = (cur_d == CW'(DIGITS - 1)) ? '0 : cur_d + CW'(1);
      end else if (btn_add) begin
        dig_d[cur_d] = (dig_d[cur_d] == 4'd9) ? 4'd0
                                              : dig_d[cur_d] + 4'd1;
      end
    end
  end

  always_comb begin
    typ_d = (state_d == S_EDIT);
    wrk_d = (state_d == S_RUN);
    shk_d = '0;
    shm_d = 4'ha;
    unique case (1'b1)
      state_d == S_OFF: begin
        shk_d = '0;
        shm_d = 4'ha;
      end
      state_d == S_RUN: begin
        shk_d = '0;
        shm_d = (mode == 2'b01) ? 4'h5 :
                (mode == 2'b11) ? 4'hc : 4'hf;
      end
      default: begin
        if (state_d == S_EDIT) shk_d = KEY_W'(dec_val(dig_d));
        else if (sel_ok)       shk_d = keys_d[key_sel];
        case (int'(key_sel))
          0:       shm_d = 4'hb;
          1:       shm_d = 4'he;
          2:       shm_d = 4'hd;
          default: shm_d = 4'(key_sel);
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      keys_q  <= '0;
      dig_q   <= '0;
      cur_q   <= '0;
      tmo_q   <= '0;
      mode_q  <= 2'b00;
      sel_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      typ_q   <= 1'b0;
      wrk_q   <= 1'b0;
      shk_q   <= '0;
      shm_q   <= 4'ha;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      dig_q   <= dig_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
      mode_q  <= mode;
      sel_q   <= key_sel;
      start_q <= start_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      typ_q   <= typ_d;
      wrk_q   <= wrk_d;
      shk_q   <= shk_d;
      shm_q   <= shm_d;
    end
  end

  assign eng_start = start_q;
  assign eng_abort = abort_q;
  assign keys_flat = keys_q;
  assign show_key  = shk_q;
  assign show_mode = shm_q;
  assign typing    = typ_q;
  assign cursor    = cur_q;
  assign working   = wrk_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rsa_ui_ctrl.sv
// Bench for rsa_ui_ctrl: directed vector table, corner sequences and
// random traffic against an abstract model of the panel behaviour.
module tb_rsa_ui_ctrl;

  localparam int KW  = 8;
  localparam int NK  = 3;
  localparam int DG  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] mode, key_sel, kg_idx;
  logic btn_add, btn_left, btn_del, btn_start;
  logic eng_busy, eng_done, kg_valid;
  logic [KW-1:0] kg_data;
  logic eng_start, eng_abort, typing, working, err;
  logic [NK*KW-1:0] keys_flat;
  logic [KW-1:0] show_key;
  logic [3:0] show_mode;
  logic [1:0] cursor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsa_ui_ctrl #(
    .KEY_W(KW), .NUM_KEYS(NK), .DIGITS(DG), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .key_sel(key_sel),
    .btn_add(btn_add), .btn_left(btn_left), .btn_del(btn_del),
    .btn_start(btn_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .kg_valid(kg_valid), .kg_idx(kg_idx), .kg_data(kg_data),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .keys_flat(keys_flat), .show_key(show_key), .show_mode(show_mode),
    .typing(typing), .cursor(cursor), .working(working), .err(err)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] btn;
    logic [7:0] key;
    logic [1:0] cur;
    logic       typ;
    logic [3:0] shm;
  } vec_t;

  typedef enum int {M_OFF, M_IDLE, M_EDIT, M_RUN} mst_t;
  mst_t        m_st;
  logic [KW-1:0] m_keys [NK];
  int          m_dig [DG];
  int          m_cur;
  int          m_cnt;
  logic [1:0]  m_pmode, m_psel;
  logic        e_start, e_abort, e_err;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic a, input logic l, input logic d,
                       input logic s);
    btn_add = a; btn_left = l; btn_del = d; btn_start = s;
    cyc();
    btn_add = 0; btn_left = 0; btn_del = 0; btn_start = 0;
  endtask

  task automatic clear_inputs();
    btn_add = 0; btn_left = 0; btn_del = 0; btn_start = 0;
    eng_busy = 0; eng_done = 0; kg_valid = 0; kg_idx = 0;
    kg_data = 0; mode = 2'b00; key_sel = 0;
  endtask

  function automatic int dec_value();
    int v, p;
    v = 0; p = 1;
    for (int i = 0; i < DG; i++) begin
      v += m_dig[i] * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_st = M_OFF;
    for (int i = 0; i < NK; i++) m_keys[i] = '0;
    for (int i = 0; i < DG; i++) m_dig[i] = 0;
    m_cur = 0; m_cnt = 0; m_pmode = 0; m_psel = 0;
    e_start = 0; e_abort = 0; e_err = 0;
  endtask

  task automatic edit_action();
    if (btn_del) begin
      m_dig[m_cur] = 0;
      if (m_cur > 0) m_cur--;
    end else if (btn_left) begin
      m_cur = (m_cur + 1) % DG;
    end else if (btn_add) begin
      m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
    end
  endtask

  task automatic model_step();
    int v;
    e_start = 0; e_abort = 0; e_err = 0;
    if (mode == 2'b00) begin
      if (m_st == M_RUN) e_abort = 1;
      m_st = M_OFF;
      for (int i = 0; i < NK; i++) m_keys[i] = '0;
      for (int i = 0; i < DG; i++) m_dig[i] = 0;
      m_cur = 0;
    end else begin
      case (m_st)
        M_OFF: m_st = M_IDLE;
        M_IDLE: begin
          if (btn_start) begin
            e_start = 1; m_cnt = 0; m_st = M_RUN;
          end else if (mode >= 2 && (btn_add || btn_left || btn_del)) begin
            for (int i = 0; i < DG; i++) m_dig[i] = 0;
            m_cur = 0; m_st = M_EDIT;
            edit_action();
          end
        end
        M_EDIT: begin
          if (mode != m_pmode || key_sel != m_psel) begin
            m_st = M_IDLE;
          end else if (btn_start) begin
            v = dec_value();
            if (v > (1 << KW) - 1) e_err = 1;
            else begin
              m_keys[key_sel] = v[KW-1:0];
              m_st = M_IDLE;
            end
          end else begin
            edit_action();
          end
        end
        M_RUN: begin
          if (mode != m_pmode) begin
            e_abort = 1; m_st = M_IDLE;
          end else begin
            if (kg_valid && mode == 2'b01) begin
              if (int'(kg_idx) >= NK) e_err = 1;
              else m_keys[kg_idx] = kg_data;
            end
            if (eng_done) m_st = M_IDLE;
            else begin
              m_cnt++;
              if (m_cnt == TMO) begin
                e_err = 1; e_abort = 1; m_st = M_IDLE;
              end
            end
          end
        end
        default: m_st = M_OFF;
      endcase
    end
    m_pmode = mode;
    m_psel = key_sel;
  endtask

  task automatic compare_all();
    logic [3:0] em;
    logic [KW-1:0] ek;
    int v;
    v = dec_value();
    case (m_st)
      M_OFF:  begin em = 4'ha; ek = '0; end
      M_RUN:  begin
        em = (mode == 2'b01) ? 4'h5 : (mode == 2'b11) ? 4'hc : 4'hf;
        ek = '0;
      end
      default: begin
        em = (key_sel == 0) ? 4'hb : (key_sel == 1) ? 4'he :
             (key_sel == 2) ? 4'hd : 4'(key_sel);
        ek = (m_st == M_EDIT) ? v[KW-1:0] : m_keys[key_sel];
      end
    endcase
    chk("r_eng_start", 64'(eng_start), 64'(e_start));
    chk("r_eng_abort", 64'(eng_abort), 64'(e_abort));
    chk("r_err", 64'(err), 64'(e_err));
    chk("r_typing", 64'(typing), 64'(m_st == M_EDIT));
    chk("r_working", 64'(working), 64'(m_st == M_RUN));
    chk("r_cursor", 64'(cursor), 64'(m_cur));
    chk("r_show_key", 64'(show_key), 64'(ek));
    chk("r_show_mode", 64'(show_mode), 64'(em));
    chk("r_keys", 64'(keys_flat), 64'({m_keys[2], m_keys[1], m_keys[0]}));
  endtask

  vec_t tv [18];
  int n;

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) cyc();
    chk("rst_show_mode", 64'(show_mode), 64'h a);
    chk("rst_show_key", 64'(show_key), 64'h0);
    chk("rst_flags", 64'({eng_start, eng_abort, err, typing, working}), 64'h0);
    chk("rst_cursor", 64'(cursor), 64'h0);
    chk("rst_keys", 64'(keys_flat), 64'h0);
    rst = 0;

    // commit 23 into key 0, then cursor wrap and del-over-add priority
    tv[0]  = '{2'b11, 2'd0, 4'b0000, 8'd0,  2'd0, 1'b0, 4'hb};
    tv[1]  = '{2'b11, 2'd0, 4'b0001, 8'd1,  2'd0, 1'b1, 4'hb};
    tv[2]  = '{2'b11, 2'd0, 4'b0001, 8'd2,  2'd0, 1'b1, 4'hb};
    tv[3]  = '{2'b11, 2'd0, 4'b0001, 8'd3,  2'd0, 1'b1, 4'hb};
    tv[4]  = '{2'b11, 2'd0, 4'b0010, 8'd3,  2'd1, 1'b1, 4'hb};
    tv[5]  = '{2'b11, 2'd0, 4'b0001, 8'd13, 2'd1, 1'b1, 4'hb};
    tv[6]  = '{2'b11, 2'd0, 4'b0001, 8'd23, 2'd1, 1'b1, 4'hb};
    tv[7]  = '{2'b11, 2'd0, 4'b1000, 8'd23, 2'd1, 1'b0, 4'hb};
    tv[8]  = '{2'b11, 2'd0, 4'b0010, 8'd0,  2'd1, 1'b1, 4'hb};
    tv[9]  = '{2'b11, 2'd0, 4'b0010, 8'd0,  2'd2, 1'b1, 4'hb};
    tv[10] = '{2'b11, 2'd0, 4'b0010, 8'd0,  2'd3, 1'b1, 4'hb};
    tv[11] = '{2'b11, 2'd0, 4'b0010, 8'd0,  2'd0, 1'b1, 4'hb};
    tv[12] = '{2'b11, 2'd0, 4'b0001, 8'd1,  2'd0, 1'b1, 4'hb};
    tv[13] = '{2'b11, 2'd0, 4'b0010, 8'd1,  2'd1, 1'b1, 4'hb};
    tv[14] = '{2'b11, 2'd0, 4'b0001, 8'd11, 2'd1, 1'b1, 4'hb};
    tv[15] = '{2'b11, 2'd0, 4'b0101, 8'd1,  2'd0, 1'b1, 4'hb};
    tv[16] = '{2'b11, 2'd0, 4'b0100, 8'd0,  2'd0, 1'b1, 4'hb};
    tv[17] = '{2'b11, 2'd1, 4'b0000, 8'd0,  2'd0, 1'b0, 4'he};

    for (int i = 0; i < 18; i++) begin
      mode = tv[i].mode;
      key_sel = tv[i].sel;
      {btn_start, btn_del, btn_left, btn_add} = tv[i].btn;
      cyc();
      chk($sformatf("vec%0d_show_key", i), 64'(show_key), 64'(tv[i].key));
      chk($sformatf("vec%0d_cursor", i), 64'(cursor), 64'(tv[i].cur));
      chk($sformatf("vec%0d_typing", i), 64'(typing), 64'(tv[i].typ));
      chk($sformatf("vec%0d_show_mode", i), 64'(show_mode), 64'(tv[i].shm));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'h0);
    end
    btn_add = 0; btn_left = 0; btn_del = 0; btn_start = 0;
    chk("commit_key0", 64'(keys_flat[7:0]), 64'd23);

    // overflow: 256 does not fit in 8 bits
    key_sel = 0;
    cyc();
    repeat (6) press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    repeat (5) press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    repeat (2) press(1, 0, 0, 0);
    chk("ovf_typing_before", 64'(typing), 64'h1);
    press(0, 0, 0, 1);
    chk("ovf_err", 64'(err), 64'h1);
    chk("ovf_typing", 64'(typing), 64'h1);
    chk("ovf_key0", 64'(keys_flat[7:0]), 64'd23);
    cyc();
    chk("ovf_err_width", 64'(err), 64'h0);
    chk("ovf_typing_hold", 64'(typing), 64'h1);
    mode = 2'b10;
    cyc();
    chk("modechg_abandon", 64'(typing), 64'h0);
    chk("modechg_key0", 64'(keys_flat[7:0]), 64'd23);

    // keygen run with result written alongside eng_done
    mode = 2'b01;
    cyc();
    press(0, 0, 0, 1);
    chk("kg_start", 64'(eng_start), 64'h1);
    chk("kg_working", 64'(working), 64'h1);
    chk("kg_show_mode", 64'(show_mode), 64'h5);
    cyc();
    chk("kg_start_once", 64'(eng_start), 64'h0);
    chk("kg_working_hold", 64'(working), 64'h1);
    kg_valid = 1; kg_idx = 2; kg_data = 8'ha5; eng_done = 1;
    cyc();
    kg_valid = 0; eng_done = 0;
    chk("kg_key2", 64'(keys_flat[23:16]), 64'ha5);
    chk("kg_idle", 64'(working), 64'h0);
    chk("kg_err", 64'(err), 64'h0);

    // abort by switching off during RUN
    press(0, 0, 0, 1);
    chk("ab_working", 64'(working), 64'h1);
    mode = 2'b00;
    cyc();
    chk("ab_abort", 64'(eng_abort), 64'h1);
    chk("ab_working_off", 64'(working), 64'h0);
    chk("ab_show_mode", 64'(show_mode), 64'ha);
    chk("ab_keys", 64'(keys_flat), 64'h0);
    cyc();
    chk("ab_abort_once", 64'(eng_abort), 64'h0);

    // timeout after TMO cycles without eng_done
    mode = 2'b11;
    cyc();
    press(0, 0, 0, 1);
    n = 0;
    while (working && n < 40) begin
      n++;
      cyc();
    end
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(err), 64'h1);
    chk("tmo_abort", 64'(eng_abort), 64'h1);
    cyc();
    chk("tmo_pulse_once", 64'({err, eng_abort}), 64'h0);

    // reset while running must not abort the engine
    press(0, 0, 0, 1);
    chk("rr_working", 64'(working), 64'h1);
    rst = 1;
    cyc();
    chk("rr_abort", 64'(eng_abort), 64'h0);
    chk("rr_working_off", 64'(working), 64'h0);
    chk("rr_show_mode", 64'(show_mode), 64'ha);
    cyc();
    chk("rr_abort_hold", 64'(eng_abort), 64'h0);

    // random traffic against the model
    clear_inputs();
    cyc();
    rst = 0;
    model_reset();
    mode = 2'($urandom_range(3, 1));
    for (int i = 0; i < 3000 && errors < 50; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) key_sel = 2'($urandom_range(2));
      btn_add   = ($urandom_range(3) == 0);
      btn_left  = ($urandom_range(3) == 0);
      btn_del   = ($urandom_range(3) == 0);
      btn_start = ($urandom_range(7) == 0);
      eng_busy  = 1'($urandom_range(1));
      eng_done  = ($urandom_range(7) == 0);
      kg_valid  = ($urandom_range(3) == 0);
      kg_idx    = 2'($urandom_range(3));
      kg_data   = 8'($urandom_range(255));
      model_step();
      cyc();
      compare_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_ui_ctrl.md
RSA_UI_CTRL -- requirements
Module: rsa_ui_ctrl

Interface
REQ-001 Parameter KEY_W, default 32, key width in bits (8..32).
REQ-002 Parameter NUM_KEYS, default 3, number of stored keys (3..8); index 0 = n, 1 = e, 2 = d.
REQ-003 Parameter DIGITS, default 10, decimal digits in the edit buffer (DIGITS*log2(10) >= KEY_W).
REQ-004 Parameter TIMEOUT, default 2**24, maximum RUN-state cycles before the operation is aborted.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports, clock and reset first:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- mode  in  2  00 off, 01 keygen, 11 encrypt, 10 decrypt.
- key_sel  in  clog2(NUM_KEYS)  selected key index.
- btn_add, btn_left, btn_del, btn_start  in  1 each  debounced single-cycle pulses.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine completion pulse.
- kg_valid  in  1  keygen result strobe.
- kg_idx  in  clog2(NUM_KEYS)  keygen result index.
- kg_data  in  KEY_W  keygen result value.
- eng_start  out  1  one-cycle engine start pulse.
- eng_abort  out  1  one-cycle engine abort pulse.
- keys_flat  out  NUM_KEYS*KEY_W  key k at bits [k*KEY_W +: KEY_W].
- show_key  out  KEY_W  value to display.
- show_mode  out  4  display mode code.
- typing  out  1  edit in progress.
- cursor  out  clog2(DIGITS)  edit digit position, 0 = least significant.
- working  out  1  engine operation in progress.
- err  out  1  one-cycle error pulse.

Function
REQ-007 The FSM SHALL have four states: OFF, IDLE, EDIT, RUN; all outputs are registered.
REQ-008 When mode==00, the FSM SHALL enter OFF on the next edge from any state and clear all keys, the edit buffer and the cursor; if it leaves RUN this way, eng_abort pulses.
REQ-009 In OFF, a mode!=00 SHALL move the FSM to IDLE on the next edge.
REQ-010 In IDLE with mode in {10,11}, btn_add/btn_left/btn_del SHALL enter EDIT with buffer = all zeros and cursor = 0, then apply that same button's action.
- In mode 01 these buttons are ignored.
REQ-011 In EDIT, button actions SHALL be:
- btn_add: digit[cursor] = (digit+1) mod 10.
- btn_left: cursor = (cursor+1) mod DIGITS.
- btn_del: digit[cursor] = 0 and cursor = max(cursor-1, 0).
REQ-012 Simultaneous buttons SHALL be resolved by priority start > del > left > add; only one action is taken per cycle.
REQ-013 In EDIT, btn_start SHALL compute V = sum of digit[i]*10^i.
- If V <= 2^KEY_W-1: write V to key[key_sel] and go to IDLE.
- Otherwise: pulse err, stay in EDIT, buffer unchanged.
REQ-014 In EDIT, any change of key_sel or mode SHALL abandon the edit (no key write) and return to IDLE, or to OFF when mode==00.
REQ-015 In IDLE, btn_start with mode!=00 SHALL pulse eng_start for exactly one cycle and enter RUN.
REQ-016 In RUN:
- working = 1.
- eng_done returns to IDLE on the next edge.
- Any mode change pulses eng_abort and goes to IDLE, or OFF when mode==00.
- Buttons are ignored.
REQ-017 In RUN, TIMEOUT consecutive cycles without eng_done SHALL pulse err and eng_abort together and return to IDLE.
REQ-018 kg_valid SHALL write kg_data to key[kg_idx] only in RUN with mode==01.
- kg_idx >= NUM_KEYS is dropped and pulses err.
- If a kg_valid write and an eng_done occur in the same cycle, the write is performed.
REQ-019 show_key SHALL be:
- 0 in OFF and RUN.
- The current V truncated to KEY_W bits in EDIT.
- key[key_sel] in IDLE.
REQ-020 show_mode SHALL be:
- OFF: 4'ha.
- RUN: 4'h5 / 4'hc / 4'hf for mode 01 / 11 / 10.
- Otherwise by key_sel: 0 -> 4'hb, 1 -> 4'he, 2 -> 4'hd, k >= 3 -> k.
REQ-021 typing SHALL be 1 only in EDIT; working SHALL be 1 only in RUN.

Reset
REQ-022 While rst is high, all of the following SHALL be held:
- State = OFF.
- All keys, edit buffer, cursor and timeout counter = 0.
- eng_start, eng_abort, err, typing, working = 0.
- show_key = 0; show_mode = 4'ha.
REQ-023 rst asserted during RUN SHALL NOT produce an eng_abort pulse; the engine shares rst.

Verification
REQ-024 Edit and commit: rst, mode=11, key_sel=0, btn_add x3, btn_left, btn_add x2, btn_start -> key[0]=23; state IDLE; show_key=23; show_mode=4'hb.
REQ-025 Overflow: KEY_W=8, enter 256, btn_start -> err pulses 1 cycle; typing stays 1; key unchanged.
REQ-026 Keygen: mode=01, btn_start -> eng_start high exactly 1 cycle; working=1; show_mode=4'h5. Then kg_valid idx 2 data 0x1234 together with eng_done -> key[2]=0x1234; IDLE.
REQ-027 Abort: in RUN, switch mode to 00 -> eng_abort 1 cycle; OFF; all keys 0; show_mode=4'ha.
REQ-028 Timeout: TIMEOUT=16, start with no eng_done -> err and eng_abort pulse at cycle 16; working=0.
REQ-029 Priority and wrap: DIGITS=4, cursor=3, btn_left -> cursor=0. btn_del and btn_add in the same cycle -> only the delete is applied.
